// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store bus master: funct3 access codes,
// FSM state type and the lane/extension helper functions.
package lsu_pkg;

    // funct3 access codes (loads and stores share B/H/W encodings)
    localparam logic [2:0] MEM_B  = 3'b000;
    localparam logic [2:0] MEM_H  = 3'b001;
    localparam logic [2:0] MEM_W  = 3'b010;
    localparam logic [2:0] MEM_BU = 3'b100;
    localparam logic [2:0] MEM_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_WAIT_R = 2'd2,
        ST_RESP   = 2'd3
    } lsu_state_e;

    // Byte enables for an access of the given size at byte offset off.
    function automatic logic [3:0] be_gen(input logic [2:0] mode, input logic [1:0] off);
        logic [3:0] be;
        case (mode[1:0])
            2'b00:   be = 4'b0001 << off;
            2'b01:   be = 4'b0011 << off;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Move the addressed lane down to bit 0 and sign/zero extend it.
    function automatic logic [31:0] load_extend(input logic [2:0] mode, input logic [1:0] off,
                                                input logic [31:0] word);
        logic [31:0] sh;
        logic [31:0] res;
        sh = word >> {off, 3'b000};
        case (mode)
            MEM_B:   res = {{24{sh[7]}}, sh[7:0]};
            MEM_H:   res = {{16{sh[15]}}, sh[15:0]};
            MEM_BU:  res = {24'd0, sh[7:0]};
            MEM_HU:  res = {16'd0, sh[15:0]};
            default: res = sh;
        endcase
        return res;
    endfunction

    // Illegal funct3 for the direction, or an address not aligned to the size.
    function automatic logic access_err(input logic we, input logic [2:0] mode, input logic [1:0] off);
        logic illegal;
        logic misaligned;
        illegal    = (mode == 3'b011) || (mode[2:1] == 2'b11) || (mode[2] && we);
        misaligned = ((mode[1:0] == 2'b01) && off[0]) || ((mode[1:0] == 2'b10) && (off != 2'b00));
        return illegal || misaligned;
    endfunction

endpackage

// File: rtl/lsu_bus_master_align.sv
// Combinational lane logic: byte enables, store data shift, access error
// check for the incoming request, and load data extraction for the
// captured access.
module lsu_align
    import lsu_pkg::*;
(
    input  logic        req_we_i,
    input  logic [2:0]  req_mode_i,
    input  logic [1:0]  req_off_i,
    input  logic [31:0] req_wdata_i,
    input  logic [2:0]  ld_mode_i,
    input  logic [1:0]  ld_off_i,
    input  logic [31:0] ld_word_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic        err_o,
    output logic [31:0] ld_data_o
);

    // Request-side fields are derived from the live request; load data uses
    // the mode/offset captured at accept time.
    always_comb begin
        be_o      = be_gen(req_mode_i, req_off_i);
        wdata_o   = req_wdata_i << {req_off_i, 3'b000};
        err_o     = access_err(req_we_i, req_mode_i, req_off_i);
        ld_data_o = load_extend(ld_mode_i, ld_off_i, ld_word_i);
    end

endmodule

// File: rtl/lsu_bus_master.sv
// Load/store bus master: accepts one core access at a time, issues it on a
// valid/ready memory channel, waits for read data and returns a one-cycle
// response. A timeout counter aborts accesses that memory never completes.
module lsu_bus_master
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [2:0]  req_mode_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        resp_valid_o,
    output logic [31:0] resp_rdata_o,
    output logic        resp_err_o,
    output logic        mem_valid_o,
    input  logic        mem_ready_i,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i
);

    localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYCLES) > 8) ? $clog2(TIMEOUT_CYCLES) : 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    lsu_state_e       state_q;
    logic [2:0]       mode_q;
    logic [1:0]       off_q;
    logic [CNT_W-1:0] cnt_q;
    logic             req_ready_q;
    logic             resp_valid_q;
    logic [31:0]      resp_rdata_q;
    logic             resp_err_q;
    logic             mem_valid_q;
    logic             mem_we_q;
    logic [3:0]       mem_be_q;
    logic [31:0]      mem_addr_q;
    logic [31:0]      mem_wdata_q;

    logic [3:0]       acc_be;
    logic [31:0]      acc_wdata;
    logic             acc_err;
    logic [31:0]      ld_data;
    logic             cnt_expired;

    lsu_align u_align (
        .req_we_i    (req_we_i),
        .req_mode_i  (req_mode_i),
        .req_off_i   (req_addr_i[1:0]),
        .req_wdata_i (req_wdata_i),
        .ld_mode_i   (mode_q),
        .ld_off_i    (off_q),
        .ld_word_i   (mem_rdata_i),
        .be_o        (acc_be),
        .wdata_o     (acc_wdata),
        .err_o       (acc_err),
        .ld_data_o   (ld_data)
    );

    assign cnt_expired = (cnt_q == CNT_LAST);

    // Transaction FSM with all outputs registered; the timeout counter runs
    // from ISSUE entry through WAIT_R without restarting.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            mode_q       <= '0;
            off_q        <= '0;
            cnt_q        <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            mem_valid_q  <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_be_q     <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid_i) begin
                        mode_q      <= req_mode_i;
                        off_q       <= req_addr_i[1:0];
                        mem_we_q    <= req_we_i;
                        mem_be_q    <= acc_be;
                        mem_addr_q  <= {req_addr_i[31:2], 2'b00};
                        mem_wdata_q <= acc_wdata;
                        req_ready_q <= 1'b0;
                        if (acc_err) begin
                            state_q      <= ST_RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                            resp_rdata_q <= '0;
                        end else begin
                            state_q     <= ST_ISSUE;
                            mem_valid_q <= 1'b1;
                            cnt_q       <= '0;
                        end
                    end
                end
                ST_ISSUE: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (mem_ready_i) begin
                        mem_valid_q <= 1'b0;
                        if (mem_we_q) begin
                            state_q      <= ST_RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b0;
                            resp_rdata_q <= '0;
                        end else begin
                            state_q <= ST_WAIT_R;
                        end
                    end else if (cnt_expired) begin
                        mem_valid_q  <= 1'b0;
                        state_q      <= ST_RESP;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b1;
                        resp_rdata_q <= '0;
                    end
                end
                ST_WAIT_R: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (mem_rvalid_i) begin
                        state_q      <= ST_RESP;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b0;
                        resp_rdata_q <= ld_data;
                    end else if (cnt_expired) begin
                        state_q      <= ST_RESP;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b1;
                        resp_rdata_q <= '0;
                    end
                end
                ST_RESP: begin
                    state_q      <= ST_IDLE;
                    resp_valid_q <= 1'b0;
                    resp_err_q   <= 1'b0;
                    resp_rdata_q <= '0;
                    req_ready_q  <= 1'b1;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign req_ready_o  = req_ready_q;
    assign resp_valid_o = resp_valid_q;
    assign resp_rdata_o = resp_rdata_q;
    assign resp_err_o   = resp_err_q;
    assign mem_valid_o  = mem_valid_q;
    assign mem_we_o     = mem_we_q;
    assign mem_be_o     = mem_be_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_wdata_o  = mem_wdata_q;

endmodule

// File: tb/tb_lsu_bus_master.sv
// Self-checking bench for lsu_bus_master: directed scenarios plus random
// accesses compared against an arithmetic reference model.
module tb_lsu_bus_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_we;
    logic [2:0]  req_mode;
    logic [31:0] req_addr, req_wdata;
    logic        mem_ready, mem_rvalid;
    logic [31:0] mem_rdata;

    logic        req_ready, resp_valid, resp_err, mem_valid, mem_we;
    logic [31:0] resp_rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_be;

    logic        to_req_ready, to_resp_valid, to_resp_err, to_mem_valid, to_mem_we;
    logic [31:0] to_resp_rdata, to_mem_addr, to_mem_wdata;
    logic [3:0]  to_mem_be;

    int errors = 0;
    int checks = 0;

    // results of the most recent run_txn
    int          r_lat;
    logic        r_err, r_saw_mv, r_mwe, r_mem_ok, r_post_ok;
    logic [31:0] r_rdata, r_mwd, r_maddr;
    logic [3:0]  r_be;

    always #5 clk = ~clk;

    lsu_bus_master dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
        .req_mode_i(req_mode), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .resp_valid_o(resp_valid), .resp_rdata_o(resp_rdata), .resp_err_o(resp_err),
        .mem_valid_o(mem_valid), .mem_ready_i(mem_ready), .mem_we_o(mem_we),
        .mem_be_o(mem_be), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata)
    );

    lsu_bus_master #(.TIMEOUT_CYCLES(8)) dut_to (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_ready_o(to_req_ready), .req_we_i(req_we),
        .req_mode_i(req_mode), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .resp_valid_o(to_resp_valid), .resp_rdata_o(to_resp_rdata), .resp_err_o(to_resp_err),
        .mem_valid_o(to_mem_valid), .mem_ready_i(mem_ready), .mem_we_o(to_mem_we),
        .mem_be_o(to_mem_be), .mem_addr_o(to_mem_addr), .mem_wdata_o(to_mem_wdata),
        .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        step();
    endtask

    // Reference: access size in bytes from funct3, lane math by powers of 256.
    function automatic void ref_model(input logic we, input logic [2:0] mode, input logic [31:0] addr,
                                      input logic [31:0] wd, input logic [31:0] rdat,
                                      output logic err, output logic [3:0] be,
                                      output logic [31:0] mwd, output logic [31:0] rdata);
        longint size, off, v, p_off, p_size;
        off = longint'(addr) % 4;
        case (mode)
            3'd0, 3'd4: size = 1;
            3'd1, 3'd5: size = 2;
            3'd2:       size = 4;
            default:    size = 0;
        endcase
        if (size == 0) begin
            err  = 1'b1;
            size = 4;
        end else begin
            err = (we && mode >= 3'd4) || (off % size != 0);
        end
        p_off  = longint'(1) << (8 * off);
        p_size = longint'(1) << (8 * size);
        be     = 4'(((longint'(1) << size) - 1) << off);
        mwd    = 32'(longint'(wd) * p_off);
        v      = (longint'(rdat) / p_off) % p_size;
        if (mode < 3'd4 && v >= p_size / 2) v = v - p_size;
        rdata  = (we || err) ? 32'd0 : 32'(v);
    endfunction

    // Drives one access and plays the memory side; reports what it observed.
    task automatic run_txn(input logic we, input logic [2:0] mode, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [31:0] rdat, input int rdl, input int rvd);
        int   n_mv, after;
        logic hs;
        r_lat = -1; r_err = 1'b0; r_rdata = '0; r_saw_mv = 1'b0; r_be = '0; r_mwd = '0;
        r_maddr = '0; r_mwe = 1'b0; r_mem_ok = 1'b1; r_post_ok = 1'b0;
        n_mv = 0; after = 0; hs = 1'b0;
        for (int i = 0; i < 50 && req_ready !== 1'b1; i++) step();
        req_valid = 1'b1; req_we = we; req_mode = mode; req_addr = addr; req_wdata = wd;
        step();
        req_valid = 1'b0; req_we = 1'($urandom); req_mode = 3'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
        for (int cyc = 1; cyc <= 300; cyc++) begin
            mem_rvalid = 1'b0;
            mem_rdata  = $urandom;
            if (mem_ready) begin
                hs = 1'b1;
                mem_ready = 1'b0;
            end
            if (resp_valid === 1'b1) begin
                r_lat = cyc; r_err = resp_err; r_rdata = resp_rdata;
                break;
            end
            if (mem_valid === 1'b1) begin
                if (hs) r_mem_ok = 1'b0;
                else if (!r_saw_mv) begin
                    r_saw_mv = 1'b1; r_be = mem_be; r_mwd = mem_wdata; r_maddr = mem_addr; r_mwe = mem_we;
                end else if ({mem_we, mem_be, mem_addr, mem_wdata} !== {r_mwe, r_be, r_maddr, r_mwd})
                    r_mem_ok = 1'b0;
                n_mv++;
                if (!hs && n_mv > rdl) mem_ready = 1'b1;
            end else if (r_saw_mv && !hs) begin
                r_mem_ok = 1'b0;
            end
            if (hs && !we) begin
                after++;
                if (after == rvd) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = rdat;
                end
            end
            step();
        end
        mem_ready = 1'b0; mem_rvalid = 1'b0;
        step();
        r_post_ok = (req_ready === 1'b1) && (resp_valid === 1'b0);
    endtask

    task automatic test_reset();
        repeat (2) step();
        checks++;
        if ({req_ready, resp_valid, resp_err, mem_valid, mem_we, mem_be} !== 9'b1_0000_0000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 100000000",
                     {req_ready, resp_valid, resp_err, mem_valid, mem_we, mem_be});
        end
        checks++;
        if ({resp_rdata, mem_addr, mem_wdata} !== 96'd0) begin
            errors++;
            $display("FAIL reset_data: rdata=%h addr=%h wdata=%h expected all 0", resp_rdata, mem_addr, mem_wdata);
        end
        #2;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_store_byte();
        run_txn(1'b1, 3'b000, 32'h0000_0103, 32'h0000_00AB, 32'h0, 0, 1);
        checks++; if (r_lat !== 2) begin errors++; $display("FAIL sb_latency: got %0d expected 2", r_lat); end
        checks++; if (r_err !== 1'b0) begin errors++; $display("FAIL sb_err: got %b expected 0", r_err); end
        checks++; if (r_be !== 4'b1000) begin errors++; $display("FAIL sb_be: got %b expected 1000", r_be); end
        checks++; if (r_mwd !== 32'hAB00_0000) begin errors++; $display("FAIL sb_wdata: got %h expected ab000000", r_mwd); end
        checks++; if (r_maddr !== 32'h0000_0100) begin errors++; $display("FAIL sb_addr: got %h expected 00000100", r_maddr); end
        checks++; if (r_mwe !== 1'b1) begin errors++; $display("FAIL sb_we: got %b expected 1", r_mwe); end
        checks++; if (r_rdata !== 32'd0) begin errors++; $display("FAIL sb_rdata: got %h expected 0", r_rdata); end
        checks++; if (r_post_ok !== 1'b1) begin errors++; $display("FAIL sb_return_idle: got %b expected 1", r_post_ok); end
    endtask

    task automatic test_load_byte();
        run_txn(1'b0, 3'b000, 32'h0000_0102, 32'h0, 32'h12F4_5678, 0, 1);
        checks++; if (r_lat !== 3) begin errors++; $display("FAIL lb_latency: got %0d expected 3", r_lat); end
        checks++; if (r_rdata !== 32'hFFFF_FFF4) begin errors++; $display("FAIL lb_rdata: got %h expected fffffff4", r_rdata); end
        checks++; if ({r_err, r_mwe, r_be} !== 6'b00_0100) begin errors++; $display("FAIL lb_fields: got %b expected 000100", {r_err, r_mwe, r_be}); end
        run_txn(1'b0, 3'b100, 32'h0000_0102, 32'h0, 32'h12F4_5678, 0, 1);
        checks++; if (r_rdata !== 32'h0000_00F4) begin errors++; $display("FAIL lbu_rdata: got %h expected 000000f4", r_rdata); end
        checks++; if (r_err !== 1'b0) begin errors++; $display("FAIL lbu_err: got %b expected 0", r_err); end
    endtask

    task automatic test_misaligned();
        run_txn(1'b0, 3'b001, 32'h0000_0101, 32'h0, 32'h1234_5678, 0, 1);
        checks++; if (r_lat !== 1) begin errors++; $display("FAIL lh_mis_latency: got %0d expected 1", r_lat); end
        checks++; if (r_err !== 1'b1) begin errors++; $display("FAIL lh_mis_err: got %b expected 1", r_err); end
        checks++; if (r_saw_mv !== 1'b0) begin errors++; $display("FAIL lh_mis_no_mem: mem_valid seen=%b expected 0", r_saw_mv); end
        checks++; if (r_rdata !== 32'd0) begin errors++; $display("FAIL lh_mis_rdata: got %h expected 0", r_rdata); end
        checks++; if (r_post_ok !== 1'b1) begin errors++; $display("FAIL lh_mis_return_idle: got %b expected 1", r_post_ok); end
    endtask

    task automatic test_wait_states();
        run_txn(1'b0, 3'b010, 32'h0000_02A0, 32'h0, 32'hDEAD_BEEF, 5, 3);
        checks++; if (r_lat !== 10) begin errors++; $display("FAIL lw_wait_latency: got %0d expected 10", r_lat); end
        checks++; if (r_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lw_wait_rdata: got %h expected deadbeef", r_rdata); end
        checks++; if (r_mem_ok !== 1'b1) begin errors++; $display("FAIL lw_wait_stable: got %b expected 1", r_mem_ok); end
        checks++; if ({r_be, r_maddr} !== {4'b1111, 32'h0000_02A0}) begin errors++; $display("FAIL lw_wait_fields: be=%b addr=%h expected 1111 000002a0", r_be, r_maddr); end
    endtask

    task automatic test_random();
        logic        we, e_err;
        logic [2:0]  mode;
        logic [31:0] addr, wd, rdat, e_mwd, e_rdata;
        logic [3:0]  e_be;
        int          rdl, rvd, e_lat;
        for (int n = 0; n < 40; n++) begin
            we = 1'($urandom); mode = 3'($urandom); addr = $urandom; wd = $urandom; rdat = $urandom;
            rdl = int'($urandom_range(0, 3)); rvd = int'($urandom_range(1, 3));
            ref_model(we, mode, addr, wd, rdat, e_err, e_be, e_mwd, e_rdata);
            e_lat = e_err ? 1 : (we ? rdl + 2 : rdl + rvd + 2);
            run_txn(we, mode, addr, wd, rdat, rdl, rvd);
            checks++; if (r_lat !== e_lat) begin errors++; $display("FAIL rnd%0d_latency: got %0d expected %0d", n, r_lat, e_lat); end
            checks++; if (r_err !== e_err) begin errors++; $display("FAIL rnd%0d_err: got %b expected %b (we=%b mode=%b addr=%h)", n, r_err, e_err, we, mode, addr); end
            checks++; if (r_rdata !== e_rdata) begin errors++; $display("FAIL rnd%0d_rdata: got %h expected %h", n, r_rdata, e_rdata); end
            checks++; if (r_post_ok !== 1'b1) begin errors++; $display("FAIL rnd%0d_return_idle: got %b expected 1", n, r_post_ok); end
            if (e_err) begin
                checks++; if (r_saw_mv !== 1'b0) begin errors++; $display("FAIL rnd%0d_no_mem: mem_valid seen=%b expected 0", n, r_saw_mv); end
            end else begin
                checks++;
                if ({r_mwe, r_be, r_maddr} !== {we, e_be, addr - (addr % 4)}) begin
                    errors++;
                    $display("FAIL rnd%0d_mem_fields: we=%b be=%b addr=%h expected %b %b %h", n, r_mwe, r_be, r_maddr, we, e_be, addr - (addr % 4));
                end
                if (we) begin
                    checks++; if (r_mwd !== e_mwd) begin errors++; $display("FAIL rnd%0d_wdata: got %h expected %h", n, r_mwd, e_mwd); end
                end
                checks++; if (r_mem_ok !== 1'b1) begin errors++; $display("FAIL rnd%0d_mem_stable: got %b expected 1", n, r_mem_ok); end
            end
        end
    endtask

    task automatic test_timeout();
        int   lat, mv_cycles;
        logic late_seen;
        pulse_reset();
        mem_ready = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_mode = 3'b010; req_addr = 32'h0000_0200;
        step();
        req_valid = 1'b0;
        lat = -1; mv_cycles = 0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            if (to_resp_valid === 1'b1) begin
                lat = cyc;
                break;
            end
            if (to_mem_valid === 1'b1) mv_cycles++;
            step();
        end
        checks++; if (lat !== 9) begin errors++; $display("FAIL timeout_latency: resp at step %0d expected 9 (8 cycles after ISSUE entry)", lat); end
        checks++; if (to_resp_err !== 1'b1) begin errors++; $display("FAIL timeout_err: got %b expected 1", to_resp_err); end
        checks++; if (to_mem_valid !== 1'b0) begin errors++; $display("FAIL timeout_mem_drop: got %b expected 0", to_mem_valid); end
        checks++; if (mv_cycles !== 8) begin errors++; $display("FAIL timeout_issue_cycles: got %0d expected 8", mv_cycles); end
        step();
        mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
        step();
        mem_rvalid = 1'b0;
        late_seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (to_resp_valid !== 1'b0) late_seen = 1'b1;
            step();
        end
        checks++; if (late_seen !== 1'b0) begin errors++; $display("FAIL timeout_late_rvalid: resp seen=%b expected 0", late_seen); end
        checks++; if (to_req_ready !== 1'b1) begin errors++; $display("FAIL timeout_ready: got %b expected 1", to_req_ready); end
        pulse_reset();
    endtask

    task automatic test_reset_midflight();
        logic late_seen;
        // reset while the store is still being offered to memory
        mem_ready = 1'b0;
        req_valid = 1'b1; req_we = 1'b1; req_mode = 3'b010; req_addr = 32'h0000_0480; req_wdata = 32'h1111_2222;
        step();
        req_valid = 1'b0;
        checks++; if (mem_valid !== 1'b1) begin errors++; $display("FAIL rst_issue_pre: mem_valid=%b expected 1", mem_valid); end
        #2; rst_n = 1'b0; #1;
        checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL rst_issue_async: mem_valid=%b expected 0", mem_valid); end
        #1; rst_n = 1'b1;
        step();
        // reset while waiting for read data
        req_valid = 1'b1; req_we = 1'b0; req_mode = 3'b010; req_addr = 32'h0000_0344;
        step();
        req_valid = 1'b0; mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        #2; rst_n = 1'b0; #1;
        checks++;
        if ({req_ready, resp_valid, resp_err, mem_valid, mem_we, mem_be} !== 9'b1_0000_0000) begin
            errors++;
            $display("FAIL rst_wait_ctrl: got %b expected 100000000", {req_ready, resp_valid, resp_err, mem_valid, mem_we, mem_be});
        end
        checks++;
        if ({resp_rdata, mem_addr, mem_wdata} !== 96'd0) begin
            errors++;
            $display("FAIL rst_wait_data: rdata=%h addr=%h wdata=%h expected all 0", resp_rdata, mem_addr, mem_wdata);
        end
        #1; rst_n = 1'b1;
        step();
        mem_rvalid = 1'b1; mem_rdata = 32'h5555_AAAA;
        step();
        mem_rvalid = 1'b0;
        late_seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (resp_valid !== 1'b0) late_seen = 1'b1;
            step();
        end
        checks++; if (late_seen !== 1'b0) begin errors++; $display("FAIL rst_no_response: resp seen=%b expected 0", late_seen); end
        run_txn(1'b0, 3'b101, 32'h0000_0346, 32'h0, 32'h8765_4321, 1, 2);
        checks++; if (r_lat !== 5) begin errors++; $display("FAIL rst_after_latency: got %0d expected 5", r_lat); end
        checks++; if (r_rdata !== 32'h0000_8765) begin errors++; $display("FAIL rst_after_rdata: got %h expected 00008765", r_rdata); end
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_mode = '0; req_addr = '0; req_wdata = '0;
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        test_reset();
        test_store_byte();
        test_load_byte();
        test_misaligned();
        test_wait_states();
        test_random();
        test_timeout();
        test_reset_midflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
